param_sync_fifo: RTL

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

---
 rtl/param_sync_fifo.sv | 95 +++++++++
 1 files changed

// File: rtl/param_sync_fifo.sv
// Parameterised single-clock FIFO with registered status flags and overflow/underflow pulses.
// Define FIFO_FWFT_EN for first-word-fall-through output; the default is a registered read port.
module param_sync_fifo #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wn,
  input  logic                     rn,
  input  logic [DATA_W-1:0]        datain,
  output logic [DATA_W-1:0]        dataout,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic              rd_ok;
  logic              wr_ok;
  logic [CW-1:0]     count_nxt;

  // A write into a full FIFO is still legal when a read frees a slot in the same cycle.
  always_comb begin
    rd_ok     = rn && !empty;
    wr_ok     = wn && (!full || rd_ok);
    count_nxt = count;
    if (wr_ok && !rd_ok) begin
      count_nxt = count + 1'b1;
    end else if (rd_ok && !wr_ok) begin
      count_nxt = count - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset && wr_ok) begin
      mem[wptr] <= datain;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_ok) begin
        rptr <= rptr + 1'b1;
      end
      count        <= count_nxt;
      full         <= (count_nxt == CW'(DEPTH));
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= CW'(AF_LEVEL));
      almost_empty <= (count_nxt <= CW'(AE_LEVEL));
      overflow     <= wn && !wr_ok;
      underflow    <= rn && !rd_ok;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is visible combinationally as soon as the registered empty flag drops.
  always_comb begin
    dataout = empty ? '0 : mem[rptr];
  end
`else
  always_ff @(posedge clock) begin
    if (!reset) begin
      dataout <= '0;
    end else if (rd_ok) begin
      dataout <= mem[rptr];
    end
  end
`endif

endmodule
